// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline: fetch FSM states, NOP encoding, default widths.
package mips_pipe_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned PC_INC     = 4;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef logic [1:0] fetch_state_t;

  localparam fetch_state_t S_REQ  = 2'd0;
  localparam fetch_state_t S_HOLD = 2'd1;
  localparam fetch_state_t S_DROP = 2'd2;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble (NOP, invalid) beats load, otherwise hold.
module if_id_reg
  import mips_pipe_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              bubble,
  input  logic [ADDR_W-1:0] pc4_in,
  input  logic [DATA_W-1:0] instr_in,
  output logic [ADDR_W-1:0] pc4,
  output logic [DATA_W-1:0] instr,
  output logic              valid
);

  // Bubble keeps PC4 so ID still sees the last sequential address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc4   <= '0;
      instr <= DATA_W'(NOP_INSTR);
      valid <= 1'b0;
    end else if (bubble) begin
      instr <= DATA_W'(NOP_INSTR);
      valid <= 1'b0;
    end else if (load) begin
      pc4   <= pc4_in;
      instr <= instr_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, fetch FSM, hold buffer and IF/ID register.
// Optional performance counters are enabled with `define IF_PERF_CNT_EN.
module if_fetch_stage
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DATA_W   = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              PCWrite,
  input  logic              IF_ID_Write,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] Redirect_PC,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] IF_ID_PC4,
  output logic [DATA_W-1:0] IF_ID_Instr,
  output logic              IF_ID_Valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`endif
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc;
  logic [ADDR_W-1:0] redir_pc, redir_pc_n;
  logic [DATA_W-1:0] hold, hold_n;
  logic [DATA_W-1:0] ld_instr;
  logic              ld, bub, stall;

  assign stall     = !PCWrite || !IF_ID_Write;
  assign pc_inc    = pc + ADDR_W'(PC_INC);
  assign imem_req  = (state != S_HOLD);
  assign imem_addr = pc;

  // State, PC, hold buffer and pending redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_REQ;
      pc       <= ADDR_W'(RESET_PC);
      redir_pc <= '0;
      hold     <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      redir_pc <= redir_pc_n;
      hold     <= hold_n;
    end
  end

  // Next-state and IF/ID control; Redirect beats stall beats advance.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    redir_pc_n = redir_pc;
    hold_n     = hold;
    ld         = 1'b0;
    bub        = 1'b0;
    ld_instr   = hold;
    case (state)
      S_REQ: begin
        if (Redirect) begin
          bub = 1'b1;
          if (imem_ready) begin
            pc_n = Redirect_PC;
          end else begin
            redir_pc_n = Redirect_PC;
            state_n    = S_DROP;
          end
        end else if (imem_ready && !stall) begin
          ld       = 1'b1;
          ld_instr = imem_rdata;
          pc_n     = pc_inc;
        end else if (imem_ready) begin
          hold_n  = imem_rdata;
          state_n = S_HOLD;
        end else if (!stall) begin
          bub = 1'b1;
        end
      end
      S_HOLD: begin
        if (Redirect) begin
          bub     = 1'b1;
          pc_n    = Redirect_PC;
          state_n = S_REQ;
        end else if (!stall) begin
          ld      = 1'b1;
          pc_n    = pc_inc;
          state_n = S_REQ;
        end
      end
      S_DROP: begin
        bub = 1'b1;
        if (Redirect) redir_pc_n = Redirect_PC;
        if (imem_ready) begin
          pc_n    = Redirect ? Redirect_PC : redir_pc;
          state_n = S_REQ;
        end
      end
      default: begin
        state_n = S_REQ;
      end
    endcase
  end

  if_id_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ld),
    .bubble   (bub),
    .pc4_in   (pc_inc),
    .instr_in (ld_instr),
    .pc4      (IF_ID_PC4),
    .instr    (IF_ID_Instr),
    .valid    (IF_ID_Valid)
  );

`ifdef IF_PERF_CNT_EN
  // Event counters: valid loads, stall cycles, redirect cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (ld)       perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (stall)    perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (Redirect) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios plus random traffic checked
// against a transaction-level model of the fetch stage.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCWrite, IF_ID_Write, Redirect;
  logic [31:0] Redirect_PC;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_PC4;
  logic [31:0] IF_ID_Instr;
  logic        IF_ID_Valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

  int n_total = 0;
  int n_bad   = 0;

  // Model: PC, IF/ID contents, captured word awaiting release, dropped request.
  logic [31:0] m_pc, m_pc4, m_instr, m_hold, m_redir;
  bit          m_valid, m_held, m_drop;
  logic [31:0] m_fc, m_sc, m_fl;

  if_fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .PCWrite     (PCWrite),
    .IF_ID_Write (IF_ID_Write),
    .Redirect    (Redirect),
    .Redirect_PC (Redirect_PC),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .IF_ID_PC4   (IF_ID_PC4),
    .IF_ID_Instr (IF_ID_Instr),
    .IF_ID_Valid (IF_ID_Valid)
`ifdef IF_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Memory contents as a function of address; 0x10 holds a known lw.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h10) return 32'h8C22_0000;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0001;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_pc4 = 32'h0; m_instr = 32'h0; m_valid = 1'b0;
    m_hold = 32'h0; m_redir = 32'h0; m_held = 1'b0; m_drop = 1'b0;
    m_fc = 32'h0; m_sc = 32'h0; m_fl = 32'h0;
  endtask

  task automatic check_outputs();
    check_eq("imem_req", 32'(imem_req), 32'(!m_held));
    if (!m_held) check_eq("imem_addr", imem_addr, m_pc);
    check_eq("if_id_pc4", IF_ID_PC4, m_pc4);
    check_eq("if_id_instr", IF_ID_Instr, m_instr);
    check_eq("if_id_valid", 32'(IF_ID_Valid), 32'(m_valid));
`ifdef IF_PERF_CNT_EN
    check_eq("perf_fetch", perf_fetch_cnt, m_fc);
    check_eq("perf_stall", perf_stall_cnt, m_sc);
    check_eq("perf_flush", perf_flush_cnt, m_fl);
`endif
  endtask

  // One clock: apply inputs, advance the model, compare after the edge.
  task automatic cyc(input bit pcw, input bit ifw, input bit rd, input logic [31:0] rpc, input bit rdy);
    logic [31:0] rdata;
    bit          stall;
    logic [31:0] n_pc, n_pc4, n_instr, n_hold, n_redir;
    bit          n_valid, n_held, n_drop, bubble, deliver;
    rdata       = mem_word(m_pc);
    PCWrite     = pcw;
    IF_ID_Write = ifw;
    Redirect    = rd;
    Redirect_PC = rpc;
    imem_ready  = rdy;
    imem_rdata  = rdata;
    stall   = !pcw || !ifw;
    n_pc = m_pc; n_pc4 = m_pc4; n_instr = m_instr; n_valid = m_valid;
    n_hold = m_hold; n_redir = m_redir; n_held = m_held; n_drop = m_drop;
    bubble = 1'b0; deliver = 1'b0;
    if (m_drop) begin
      bubble = 1'b1;
      if (rd) n_redir = rpc;
      if (rdy) begin n_pc = rd ? rpc : m_redir; n_drop = 1'b0; end
    end else if (m_held) begin
      if (rd) begin bubble = 1'b1; n_pc = rpc; n_held = 1'b0; end
      else if (!stall) begin deliver = 1'b1; n_instr = m_hold; n_held = 1'b0; end
    end else begin
      if (rd) begin
        bubble = 1'b1;
        if (rdy) n_pc = rpc;
        else begin n_redir = rpc; n_drop = 1'b1; end
      end else if (rdy && !stall) begin
        deliver = 1'b1; n_instr = rdata;
      end else if (rdy) begin
        n_hold = rdata; n_held = 1'b1;
      end else if (!stall) begin
        bubble = 1'b1;
      end
    end
    if (bubble) begin n_instr = 32'h0; n_valid = 1'b0; end
    if (deliver) begin n_pc4 = m_pc + 32'd4; n_pc = m_pc + 32'd4; n_valid = 1'b1; end
    @(posedge clk);
    #1;
    m_pc = n_pc; m_pc4 = n_pc4; m_instr = n_instr; m_valid = n_valid;
    m_hold = n_hold; m_redir = n_redir; m_held = n_held; m_drop = n_drop;
    if (deliver) m_fc++;
    if (stall) m_sc++;
    if (rd) m_fl++;
    check_outputs();
  endtask

  initial begin
    logic [31:0] rpc;
    PCWrite = 1'b1; IF_ID_Write = 1'b1; Redirect = 1'b0; Redirect_PC = '0;
    imem_ready = 1'b0; imem_rdata = '0;
    rst_n = 1'b0;
    model_reset();
    #12;
    check_eq("rst_valid", 32'(IF_ID_Valid), 32'h0);
    check_eq("rst_instr", IF_ID_Instr, 32'h0);
    check_eq("rst_pc4", IF_ID_PC4, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check_eq("rst_req", 32'(imem_req), 32'h1);
    check_eq("rst_addr", imem_addr, 32'h0);

    // Zero-wait memory: one instruction per cycle.
    for (int i = 0; i < 4; i++) begin
      check_eq("zw_addr", imem_addr, 32'(4 * i));
      cyc(1, 1, 0, 32'h0, 1);
      check_eq("zw_pc4", IF_ID_PC4, 32'(4 * (i + 1)));
      check_eq("zw_valid", 32'(IF_ID_Valid), 32'h1);
    end

    // Two-cycle stall while the fetch at 0x10 returns.
    check_eq("st_addr", imem_addr, 32'h10);
    cyc(0, 0, 0, 32'h0, 1);
    check_eq("st_req", 32'(imem_req), 32'h0);
    check_eq("st_pc4_held", IF_ID_PC4, 32'h10);
    cyc(0, 0, 0, 32'h0, 1);
    check_eq("st_pc4_held2", IF_ID_PC4, 32'h10);
    cyc(1, 1, 0, 32'h0, 1);
    check_eq("rel_pc4", IF_ID_PC4, 32'h14);
    check_eq("rel_instr", IF_ID_Instr, 32'h8C22_0000);
    check_eq("rel_valid", 32'(IF_ID_Valid), 32'h1);
    check_eq("rel_addr", imem_addr, 32'h14);

    // Redirect with a ready response at 0x20.
    for (int i = 0; i < 3; i++) cyc(1, 1, 0, 32'h0, 1);
    check_eq("rd_addr_pre", imem_addr, 32'h20);
    cyc(1, 1, 1, 32'h100, 1);
    check_eq("rd_valid", 32'(IF_ID_Valid), 32'h0);
    check_eq("rd_instr", IF_ID_Instr, 32'h0);
    check_eq("rd_addr", imem_addr, 32'h100);

    // Redirect to 0x200 while the request at 0x40 waits.
    cyc(1, 1, 1, 32'h40, 1);
    cyc(1, 1, 1, 32'h200, 0);
    check_eq("drop_addr0", imem_addr, 32'h40);
    for (int i = 0; i < 2; i++) begin
      cyc(1, 1, 0, 32'h0, 0);
      check_eq("drop_addr", imem_addr, 32'h40);
      check_eq("drop_valid", 32'(IF_ID_Valid), 32'h0);
    end
    cyc(1, 1, 0, 32'h0, 1);
    check_eq("drop_new_addr", imem_addr, 32'h200);
    check_eq("drop_valid_end", 32'(IF_ID_Valid), 32'h0);

    // Redirect and stall together in the hold state.
    cyc(0, 0, 0, 32'h0, 1);
    check_eq("hr_req", 32'(imem_req), 32'h0);
    cyc(0, 0, 1, 32'h80, 0);
    check_eq("hr_addr", imem_addr, 32'h80);
    check_eq("hr_req2", 32'(imem_req), 32'h1);
    check_eq("hr_valid", 32'(IF_ID_Valid), 32'h0);

    // PC wraps past the top of the address space.
    cyc(1, 1, 1, 32'hFFFF_FFFC, 1);
    cyc(1, 1, 0, 32'h0, 1);
    check_eq("wrap_pc4", IF_ID_PC4, 32'h0);
    check_eq("wrap_addr", imem_addr, 32'h0);

    // Reset pulsed while a request at 0x30 waits.
    cyc(1, 1, 1, 32'h30, 1);
    cyc(1, 1, 0, 32'h0, 0);
    check_eq("mr_addr_pre", imem_addr, 32'h30);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("mr_valid", 32'(IF_ID_Valid), 32'h0);
    check_eq("mr_pc4", IF_ID_PC4, 32'h0);
    check_eq("mr_addr", imem_addr, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check_eq("mr_addr_post", imem_addr, 32'h0);
    check_eq("mr_valid_post", 32'(IF_ID_Valid), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom();
      if ($urandom_range(0, 4) != 0) rpc = rpc & 32'hFFFF_FFFC;
      cyc(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 8),
          ($urandom_range(0, 9) == 0), rpc, ($urandom_range(0, 9) < 7));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC and the IF/ID pipeline register.
- Issues requests to instruction memory over a req/ready handshake.
- Obeys the stall controls (PCWrite, IF_ID_Write) from the load-use hazard unit and the branch/jump redirect from ID.
- Downstream, ID decodes IF_ID_Instr and feeds IF_ID_Rs/IF_ID_Rt back to the hazard unit.

Parameters:
RESET_PC, 32'h0000_0000, PC value after reset
ADDR_W, 32, PC / memory address width
DATA_W, 32, instruction width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
PCWrite  in  1  0 = hold PC (hazard stall)
IF_ID_Write  in  1  0 = hold IF/ID register (hazard stall)
Redirect  in  1  taken branch/jump resolved in ID; flushes IF/ID
Redirect_PC  in  ADDR_W  target address accompanying Redirect
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address, stable while imem_req=1 and imem_ready=0
imem_ready  in  1  response valid for the current request, same cycle as imem_rdata
imem_rdata  in  DATA_W  fetched instruction
IF_ID_PC4  out  ADDR_W  PC+4 of the instruction in IF/ID
IF_ID_Instr  out  DATA_W  instruction in IF/ID (32'h0 = NOP bubble)
IF_ID_Valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst_n=0): PC=RESET_PC, state=S_REQ, IF_ID_PC4=0, IF_ID_Instr=0, IF_ID_Valid=0, hold buffer=0, redir_pc=0. imem_req is combinational from state, so imem_req=1 in the first cycle after rst_n rises.
- stall = !PCWrite || !IF_ID_Write. The mixed combination PCWrite≠IF_ID_Write is treated as a full stall.
- Priority: Redirect > stall > normal advance.
- State S_REQ: imem_req=1, imem_addr=PC.
  - Redirect, imem_ready=1: response discarded; PC<=Redirect_PC; IF/ID<=bubble; stay S_REQ.
  - Redirect, imem_ready=0: redir_pc<=Redirect_PC; IF/ID<=bubble; go S_DROP. The address is held because the request is outstanding.
  - imem_ready=1, no stall: IF/ID<={PC+4, imem_rdata, 1}; PC<=PC+4; stay S_REQ. This gives 1 instruction/cycle with a zero-wait memory.
  - imem_ready=1, stall: hold<=imem_rdata; PC unchanged; IF/ID unchanged; go S_HOLD.
  - imem_ready=0, no stall: IF/ID<=bubble (Valid=0, Instr=0, PC4 unchanged).
  - imem_ready=0, stall: IF/ID unchanged.
- State S_HOLD: imem_req=0.
  - Redirect: hold discarded; PC<=Redirect_PC; IF/ID<=bubble; go S_REQ.
  - No stall: IF/ID<={PC+4, hold, 1}; PC<=PC+4; go S_REQ.
  - Stall: remain in S_HOLD with all state held.
- State S_DROP: imem_req=1, imem_addr=PC (the old address). IF/ID<=bubble every cycle, regardless of stall.
  - A new Redirect overwrites redir_pc.
  - On imem_ready: data discarded; PC<=(Redirect ? Redirect_PC : redir_pc); go S_REQ.
- Arithmetic: PC+4 wraps modulo 2^ADDR_W; 32'hFFFF_FFFC+4 = 0.
- A Redirect to an unaligned address is accepted unchanged; no alignment check.
- Reset asserted mid-request: the request is abandoned immediately; the memory must tolerate imem_req dropping.

Optional Feature:
IF_PERF_CNT_EN. When defined, three outputs are added, all cleared by rst_n and wrapping at 2^32:
- perf_fetch_cnt [31:0]: increments when IF/ID loads a valid instruction.
- perf_stall_cnt [31:0]: increments on each stall cycle.
- perf_flush_cnt [31:0]: increments on each Redirect cycle.
When undefined, these ports and counters are absent and the rest of the behaviour is identical.

Decomposition:
- Shared package mips_pipe_pkg: fetch-state enum (S_REQ, S_HOLD, S_DROP), NOP_INSTR=32'h0, PC_INC=4, ADDR_W/DATA_W defaults.
- One sub-module, if_id_reg: the IF/ID register with load/bubble/hold controls.
- PC, FSM and the hold buffer stay in if_fetch_stage.

Test Plan:
- Zero-wait memory (imem_ready=1 every cycle), RESET_PC=0: imem_addr is 0,4,8,...; IF_ID_PC4 is 4,8,12,... one cycle after each fetch; Valid=1 continuously.
- Stall of 2 cycles (PCWrite=IF_ID_Write=0) while the fetch at PC=0x10 returns 0x8C220000:
  - enters S_HOLD, IF/ID holds its previous value;
  - on release, IF/ID={0x14, 0x8C220000, 1}, the next imem_addr is 0x14, and no instruction is lost or duplicated.
- Redirect with Redirect_PC=0x100 while imem_ready=1 at PC=0x20: the next IF/ID is a bubble (Valid=0, Instr=0) and the next imem_addr is 0x100.
- Redirect to 0x200 while a request at 0x40 is pending (3 wait cycles):
  - imem_addr stays 0x40 until ready;
  - the returned data is dropped;
  - the next imem_addr is 0x200 and IF/ID shows bubbles throughout.
- Simultaneous Redirect (0x80) and stall during S_HOLD: the redirect wins; PC=0x80, IF/ID bubble, S_REQ next.
- rst_n pulsed low mid-wait at PC=0x30: outputs clear asynchronously; after release imem_addr=RESET_PC and Valid=0.
